// File: rtl/vector_memory_pkg.sv
// vector_memory_pkg: shared types and default constants for the vector memory
// block.
//   state_t   - sequencer states (IDLE, ACCESS, DRAIN, RESP)
//   region_t  - per-element decode result (ROM, RAM, unmapped)
//   DEF_*     - default memory-map constants used as module parameter defaults
//   rom_seed  - fixed contents of the ROM macro, computed from the address
package vector_memory_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DRAIN  = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    REG_ROM  = 2'd0,
    REG_RAM  = 2'd1,
    REG_NONE = 2'd2
  } region_t;

  localparam logic [31:0] DEF_RAM_BASE = 32'h0000_FFFF;
  localparam int          DEF_ROM_AW   = 16;
  localparam int          DEF_RAM_AW   = 16;

  // ROM image: XOR of all address bytes with a constant. Keeps the ROM a pure
  // function of its address, so it needs no load mechanism.
  function automatic logic [7:0] rom_seed(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
  endfunction

endpackage

// File: rtl/vector_memory_if.sv
// vector_memory_if: request/response bus of the vector memory.
//   req_valid/req_ready   - request handshake, accepted when both are high
//   req_write             - 1 = store, 0 = load
//   req_addr              - address of element 0
//   req_wdata/req_mask    - store data and per-lane enable, lane k at [k*L +: L]
//   resp_valid            - one-cycle completion pulse
//   resp_rdata/resp_error - load data and illegal-access flag, held until next response
// master = requester, slave = vector_memory.
interface vector_memory_if #(
  parameter int A     = 32,
  parameter int L     = 8,
  parameter int LANES = 4
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [A-1:0]         req_addr;
  logic [LANES*L-1:0]   req_wdata;
  logic [LANES-1:0]     req_mask;
  logic                 resp_valid;
  logic [LANES*L-1:0]   resp_rdata;
  logic                 resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_mask,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_mask,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/vector_memory_decode.sv
// mem_region_decode: combinational address decoder for one element address.
//   ea       in  A       effective element address
//   region   out         REG_ROM below RAM_BASE, REG_RAM inside the RAM window,
//                        REG_NONE past the end of the RAM
//   rom_addr out ROM_AW  ROM macro address (low bits of ea)
//   ram_addr out RAM_AW  RAM macro address (ea - RAM_BASE)
module mem_region_decode
  import vector_memory_pkg::*;
#(
  parameter int           A        = 32,
  parameter logic [A-1:0] RAM_BASE = A'(DEF_RAM_BASE),
  parameter int           ROM_AW   = DEF_ROM_AW,
  parameter int           RAM_AW   = DEF_RAM_AW
) (
  input  logic [A-1:0]      ea,
  output region_t           region,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [RAM_AW-1:0] ram_addr
);

  logic [A-1:0] ram_off;

  // NOTE: every output of an always_comb gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    ram_off  = ea - RAM_BASE;
    rom_addr = ea[ROM_AW-1:0];
    ram_addr = ram_off[RAM_AW-1:0];
    region   = REG_NONE;
    if (ea < RAM_BASE) begin
      region = REG_ROM;
    end else if ((ram_off >> RAM_AW) == '0) begin
      region = REG_RAM;
    end
  end

endmodule

// File: rtl/vector_memory_macros.sv
// Single-port synchronous memory macros used by vector_memory.
//   vm_rom: clk, addr (AW), q (W) - registered read of a fixed image
//   vm_ram: clk, we, addr (AW), d (W), q (W) - registered read, write on we;
//           a read of the address being written returns the old data
module vm_rom
  import vector_memory_pkg::*;
#(
  parameter int AW = 16,
  parameter int W  = 8
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output logic [W-1:0]  q
);

  always_ff @(posedge clk) begin
    q <= W'(rom_seed(32'(addr)));
  end

endmodule

module vm_ram #(
  parameter int AW = 16,
  parameter int W  = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  d,
  output logic [W-1:0]  q
);

  logic [W-1:0] mem [2**AW];

  // NOTE: the storage array has no reset; a memory macro cannot clear all its
  // words in one cycle, and the contents are defined by the writes only.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= d;
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/vector_memory.sv
// vector_memory: LANES-element vector load/store engine over one ROM and one
// RAM macro. One element is presented to the macros per cycle; each element
// address is decoded independently, so a vector may straddle ROM, RAM and the
// unmapped area.
//   clk  in  system clock
//   rst  in  synchronous active-high reset
//   bus  slave port of vector_memory_if (request/response handshake)
// Timeline from acceptance at cycle 0: ACCESS cycles 1..LANES, DRAIN at
// LANES+1 (last read data returns), RESP at LANES+2, IDLE again at LANES+3.
module vector_memory
  import vector_memory_pkg::*;
#(
  parameter int           A        = 32,
  parameter int           L        = 8,
  parameter int           LANES    = 4,
  parameter logic [A-1:0] RAM_BASE = A'(DEF_RAM_BASE),
  parameter int           ROM_AW   = DEF_ROM_AW,
  parameter int           RAM_AW   = DEF_RAM_AW
) (
  input logic           clk,
  input logic           rst,
  vector_memory_if.slave bus
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  state_t state, state_next;
  logic   [LW-1:0]       lane;
  logic                  accept;

  // Request captured at acceptance.
  logic                  write_q;
  logic [A-1:0]          addr_q;
  logic [LANES*L-1:0]    wdata_q;
  logic [LANES-1:0]      mask_q;

  // Current-lane decode.
  logic [A-1:0]          ea;
  region_t               region;
  logic [ROM_AW-1:0]     rom_addr;
  logic [RAM_AW-1:0]     ram_addr;
  logic                  cur_en;
  logic [L-1:0]          cur_data;
  logic                  ram_we;
  logic                  lane_err;
  logic                  load_issue;

  // Read return path: the macros answer one cycle after the lane is presented.
  logic                  pend_valid;
  logic [LW-1:0]         pend_lane;
  region_t               pend_region;
  logic [L-1:0]          rom_q, ram_q, lane_val;
  logic [LANES*L-1:0]    rbuf, rbuf_next;
  logic                  err_acc;

  logic                  resp_valid_q, resp_error_q;
  logic [LANES*L-1:0]    resp_rdata_q;

  assign bus.req_ready  = (state == IDLE) && !rst;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_error = resp_error_q;

  assign accept   = bus.req_valid && bus.req_ready;
  assign ea       = addr_q + A'(lane);
  assign cur_en   = mask_q[lane];
  assign cur_data = wdata_q[lane*L +: L];

  mem_region_decode #(
    .A(A), .RAM_BASE(RAM_BASE), .ROM_AW(ROM_AW), .RAM_AW(RAM_AW)
  ) u_decode (
    .ea(ea), .region(region), .rom_addr(rom_addr), .ram_addr(ram_addr)
  );

  // The write strobe is gated by rst so a lane presented in the reset cycle is
  // never written; lanes issued in earlier cycles are already committed.
  assign ram_we     = (state == ACCESS) && !rst && write_q && cur_en && (region == REG_RAM);
  assign load_issue = (state == ACCESS) && !write_q && cur_en;
  assign lane_err   = (state == ACCESS) && cur_en &&
                      ((region == REG_NONE) || (write_q && (region == REG_ROM)));

  vm_rom #(.AW(ROM_AW), .W(L)) u_rom (
    .clk(clk), .addr(rom_addr), .q(rom_q)
  );

  vm_ram #(.AW(RAM_AW), .W(L)) u_ram (
    .clk(clk), .we(ram_we), .addr(ram_addr), .d(cur_data), .q(ram_q)
  );

  // Merge the returning element into the lane buffer; unmapped lanes read 0.
  always_comb begin
    lane_val = '0;
    case (pend_region)
      REG_ROM: lane_val = rom_q;
      REG_RAM: lane_val = ram_q;
      default: lane_val = '0;
    endcase
    rbuf_next = rbuf;
    if (pend_valid) begin
      rbuf_next[pend_lane*L +: L] = lane_val;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ACCESS;
      ACCESS:  if (lane == LW'(LANES - 1)) state_next = DRAIN;
      DRAIN:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and process ordering cannot matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lane         <= '0;
      pend_valid   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
    end else begin
      state        <= state_next;
      pend_valid   <= load_issue;
      resp_valid_q <= (state == DRAIN);
      if (accept || (state_next != ACCESS)) begin
        lane <= '0;
      end else begin
        lane <= lane + 1'b1;
      end
      if (state == DRAIN) begin
        resp_rdata_q <= rbuf_next;
        resp_error_q <= err_acc;
      end
    end
  end

  // Datapath registers: reloaded at every acceptance, so they need no reset.
  always_ff @(posedge clk) begin
    pend_lane   <= lane;
    pend_region <= region;
    if (accept) begin
      write_q <= bus.req_write;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      mask_q  <= bus.req_mask;
      rbuf    <= '0;
      err_acc <= 1'b0;
    end else begin
      rbuf <= rbuf_next;
      if (lane_err) begin
        err_acc <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vector_memory.sv
// tb_vector_memory: directed self-checking bench for vector_memory
// (A=32, L=8, LANES=4, RAM_BASE=0x0000_FFFF, 16-bit macros).
// ROM image: byte = XOR of address bytes ^ 0xA5, so
// ROM[0xFFFD]=0xA7, ROM[0xFFFE]=0xA4, ROM[0x0000]=0xA5, ROM[0x0001]=0xA4.
module tb_vector_memory;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  vector_memory_if #(.A(32), .L(8), .LANES(4)) bus ();

  vector_memory #(
    .A(32), .L(8), .LANES(4), .RAM_BASE(32'h0000_FFFF), .ROM_AW(16), .RAM_AW(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the block idle; returns at the negedge of cycle 1.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m);
    int t;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_mask  = m;
    bus.req_valid = 1'b1;
    t = 0;
    while (!bus.req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("accept_ready", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Starts at the negedge of cycle 1; returns at the negedge of cycle 7.
  task automatic finish(input string tag, input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'd6);
    check({tag, ".rdata"}, bus.resp_rdata, exp_rd);
    check({tag, ".error"}, {31'd0, bus.resp_error}, {31'd0, exp_err});
    @(negedge clk);
    check({tag, ".pulse"}, {31'd0, bus.resp_valid}, 32'd0);
  endtask

  task automatic txn(input string tag, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] m,
                     input logic [31:0] exp_rd, input logic exp_err);
    issue(w, a, d, m);
    finish(tag, exp_rd, exp_err);
  endtask

  initial begin
    logic seen;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_mask  = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst.ready", {31'd0, bus.req_ready}, 32'd0);
    check("rst.valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst.rdata", bus.resp_rdata, 32'd0);
    check("rst.error", {31'd0, bus.resp_error}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst.ready_after", {31'd0, bus.req_ready}, 32'd1);

    // RAM offsets 0..3 <= 0C 0D 0E 0F.
    txn("init", 1'b1, 32'h0000_FFFF, 32'h0F0E_0D0C, 4'hF, 32'h0, 1'b0);

    // Store then load.
    txn("t1.store", 1'b1, 32'h0001_0000, 32'hDDCC_BBAA, 4'hF, 32'h0, 1'b0);
    txn("t1.load",  1'b0, 32'h0001_0000, 32'h0,         4'hF, 32'hDDCC_BBAA, 1'b0);

    // Masked store and masked load.
    txn("t2.store", 1'b1, 32'h0001_0000, 32'h4433_2211, 4'b0101, 32'h0, 1'b0);
    txn("t2.load",  1'b0, 32'h0001_0000, 32'h0,         4'hF,    32'hDD33_BB11, 1'b0);
    txn("t2.lmask", 1'b0, 32'h0001_0000, 32'h0,         4'b0011, 32'h0000_BB11, 1'b0);
    txn("t2.mask0", 1'b0, 32'h0001_0000, 32'h0,         4'b0000, 32'h0, 1'b0);

    // ROM/RAM straddle at RAM_BASE-2.
    txn("t3.load",  1'b0, 32'h0000_FFFD, 32'h0,         4'hF, 32'h110C_A4A7, 1'b0);
    txn("t3.store", 1'b1, 32'h0000_FFFD, 32'h9988_7766, 4'hF, 32'h0, 1'b1);
    txn("t3.check", 1'b0, 32'h0000_FFFD, 32'h0,         4'hF, 32'h9988_A4A7, 1'b0);

    // Unmapped tail and address wrap.
    txn("t4.store", 1'b1, 32'h0001_FFFD, 32'h0000_5A3C, 4'b0011, 32'h0, 1'b0);
    txn("t4.load",  1'b0, 32'h0001_FFFD, 32'h0,         4'hF,    32'h0000_5A3C, 1'b1);
    txn("t4.wrap",  1'b0, 32'hFFFF_FFFE, 32'h0,         4'b1100, 32'hA4A5_0000, 1'b0);
    txn("t4.wrapf", 1'b0, 32'hFFFF_FFFE, 32'h0,         4'hF,    32'hA4A5_0000, 1'b1);

    // Handshake: req_valid held high, fields changing during the transfer.
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h0001_0000;
    bus.req_wdata = 32'h0;
    bus.req_mask  = 4'hF;
    bus.req_valid = 1'b1;
    check("hs.ready0", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk);
    for (int n = 1; n <= 6; n++) begin
      check("hs.ready_low", {31'd0, bus.req_ready}, 32'd0);
      check("hs.valid", {31'd0, bus.resp_valid}, 32'(n == 6));
      if (n == 6) begin
        check("hs.rdata", bus.resp_rdata, 32'hDD33_BB99);
        check("hs.error", {31'd0, bus.resp_error}, 32'd0);
        bus.req_addr = 32'h0000_FFFD;
      end else begin
        bus.req_addr  = 32'h0002_0000 + 32'(n);
        bus.req_wdata = 32'h1111_1111 * 32'(n);
      end
      @(negedge clk);
    end
    check("hs.ready7", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    finish("hs.second", 32'h9988_A4A7, 1'b0);

    // Reset in the middle of a store.
    txn("t6.pre",  1'b1, 32'h0001_0100, 32'h0403_0201, 4'hF, 32'h0, 1'b0);
    txn("t6.load", 1'b0, 32'h0001_0100, 32'h0,         4'hF, 32'h0403_0201, 1'b0);
    issue(1'b1, 32'h0001_0100, 32'hD4C3_B2A1, 4'hF);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("t6.ready_in_rst", {31'd0, bus.req_ready}, 32'd0);
    @(negedge clk);
    check("t6.valid", {31'd0, bus.resp_valid}, 32'd0);
    check("t6.rdata", bus.resp_rdata, 32'd0);
    check("t6.error", {31'd0, bus.resp_error}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("t6.ready_after", {31'd0, bus.req_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen = seen | bus.resp_valid;
      @(negedge clk);
    end
    check("t6.no_resp", {31'd0, seen}, 32'd0);
    txn("t6.verify", 1'b0, 32'h0001_0100, 32'h0, 4'hF, 32'h0403_B2A1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
